dmem_resp_ctrl: RTL and testbench

DMEM_RESP_CTRL -- requirements
Module: dmem_resp_ctrl

---
 rtl/params_pkg.sv | 20 ++
 rtl/dmem_bank.sv | 31 +++
 rtl/dmem_resp_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_resp_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
`default_nettype none
// ============================================================================
// Module   : params_pkg
// Purpose  : Shared memory-subsystem sizes and the access-size encoding.
// Revision : 1.0
// ============================================================================
package params_pkg;

    localparam int MEM_SIZE   = 1024;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_size_t;

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bank
// Purpose  : Four byte-lane storage array, synchronous write, async read.
// Revision : 1.0
// ============================================================================
module dmem_bank #(
    parameter int MEM_SIZE = 1024,
    parameter int IDX_W    = $clog2(MEM_SIZE) - 2
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] word_idx_i,
    input  logic [3:0]       lane_we_i,
    input  logic [31:0]      wr_data_i,
    output logic [31:0]      rd_data_o
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [MEM_SIZE/4];

        always_ff @(posedge clk_i) begin
            if (lane_we_i[g]) begin
                r_mem[word_idx_i] <= wr_data_i[8*g +: 8];
            end
        end

        assign rd_data_o[8*g +: 8] = r_mem[word_idx_i];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_resp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp_ctrl
// Purpose  : Fixed-latency data memory with byte/half/word lane handling.
// Revision : 1.0
// ============================================================================
module dmem_resp_ctrl #(
    parameter int MEM_SIZE   = params_pkg::MEM_SIZE,
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter int LATENCY    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rd_req_valid_i,
    input  logic                     wr_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]    mem_req_address_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  params_pkg::access_size_t req_access_size_i,
    output logic [DATA_WIDTH-1:0]    mem_data_o,
    output logic                     mem_data_is_valid_o,
    output logic                     busy_o
);

    import params_pkg::*;

    localparam int         c_IDX_W  = $clog2(MEM_SIZE) - 2;
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    access_size_t          r_size;
    logic                  r_valid;
    logic                  r_busy;

    logic                  w_idle;
    logic                  w_wr_en;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [3:0]            w_lane_we;
    logic [DATA_WIDTH-1:0] w_lane_wdata;
    logic [DATA_WIDTH-1:0] w_bank_rdata;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_rd_ext;

    assign w_idle   = (r_state == IDLE);
    assign w_wr_en  = w_idle & wr_req_valid_i;
    // A simultaneous write wins; the read is simply not accepted.
    assign w_rd_acc = w_idle & rd_req_valid_i & ~wr_req_valid_i;
    assign w_addr   = w_idle ? mem_req_address_i : r_addr;

    always_comb begin
        w_lane_we    = 4'b0000;
        w_lane_wdata = wr_data_i;
        case (req_access_size_i)
            BYTE: begin
                w_lane_we    = 4'b0001 << mem_req_address_i[1:0];
                w_lane_wdata = {4{wr_data_i[7:0]}};
            end
            HALF: begin
                w_lane_we    = mem_req_address_i[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{wr_data_i[15:0]}};
            end
            WORD:    w_lane_we = 4'b1111;
            default: w_lane_we = 4'b0000;
        endcase
        if (!w_wr_en) begin
            w_lane_we = 4'b0000;
        end
    end

    dmem_bank #(
        .MEM_SIZE (MEM_SIZE),
        .IDX_W    (c_IDX_W)
    ) u_bank (
        .clk_i      (clk_i),
        .word_idx_i (w_addr[c_IDX_W+1:2]),
        .lane_we_i  (w_lane_we),
        .wr_data_i  (w_lane_wdata),
        .rd_data_o  (w_bank_rdata)
    );

    assign w_shifted = w_bank_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_rd_ext = w_bank_rdata;
        case (r_size)
            BYTE:    w_rd_ext = {24'h0, w_shifted[7:0]};
            HALF:    w_rd_ext = r_addr[1] ? {16'h0, w_bank_rdata[31:16]}
                                          : {16'h0, w_bank_rdata[15:0]};
            default: w_rd_ext = w_bank_rdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_size  <= WORD;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rd_acc) begin
                        r_addr <= mem_req_address_i;
                        r_size <= req_access_size_i;
                        r_busy <= 1'b1;
                        r_cnt  <= c_LAT_M1;
                        if (c_LAT_M1 == 4'd0) begin
                            r_state <= RESP;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        r_valid <= 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_data_is_valid_o = r_valid;
    assign busy_o              = r_busy;
    assign mem_data_o          = r_valid ? w_rd_ext : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_resp_ctrl
// Purpose  : Directed self-checking bench for dmem_resp_ctrl (LATENCY 4 and 1).
// Revision : 1.0
// ============================================================================
module tb_dmem_resp_ctrl;

    import params_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_v;
    logic         wr_v;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    access_size_t size;

    logic [31:0]  data4, data1;
    logic         valid4, valid1;
    logic         busy4, busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_resp_ctrl #(.LATENCY(4)) dut4 (
        .clk_i               (clk),
        .rst_i               (rst_n),
        .rd_req_valid_i      (rd_v),
        .wr_req_valid_i      (wr_v),
        .mem_req_address_i   (addr),
        .wr_data_i           (wdata),
        .req_access_size_i   (size),
        .mem_data_o          (data4),
        .mem_data_is_valid_o (valid4),
        .busy_o              (busy4)
    );

    dmem_resp_ctrl #(.LATENCY(1)) dut1 (
        .clk_i               (clk),
        .rst_i               (rst_n),
        .rd_req_valid_i      (rd_v),
        .wr_req_valid_i      (wr_v),
        .mem_req_address_i   (addr),
        .wr_data_i           (wdata),
        .req_access_size_i   (size),
        .mem_data_o          (data1),
        .mem_data_is_valid_o (valid1),
        .busy_o              (busy1)
    );

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input access_size_t s);
        @(negedge clk);
        addr = a; wdata = d; size = s; wr_v = 1'b1;
        @(negedge clk);
        wr_v = 1'b0;
    endtask

    // Issues one read and checks valid/busy/data for every cycle up to one past the pulse.
    task automatic read_check(input logic [31:0] a, input access_size_t s,
                              input logic [31:0] exp, input int lat, input string name);
        logic [31:0] d;
        logic        v, b;
        @(negedge clk);
        addr = a; size = s; rd_v = 1'b1;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            rd_v = 1'b0;
            d = (lat == 1) ? data1  : data4;
            v = (lat == 1) ? valid1 : valid4;
            b = (lat == 1) ? busy1  : busy4;
            n_cmp++;
            if (v !== (k == lat)) begin
                n_err++;
                $display("FAIL %s valid k=%0d got %b expected %b", name, k, v, (k == lat));
            end
            n_cmp++;
            if (b !== (k <= lat)) begin
                n_err++;
                $display("FAIL %s busy k=%0d got %b expected %b", name, k, b, (k <= lat));
            end
            n_cmp++;
            if (d !== ((k == lat) ? exp : 32'h0)) begin
                n_err++;
                $display("FAIL %s data k=%0d got %h expected %h", name, k, d,
                         ((k == lat) ? exp : 32'h0));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; rd_v = 1'b0; wr_v = 1'b0;
        addr = '0; wdata = '0; size = WORD;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL reset valid4 got %b expected 0", valid4); end
        n_cmp++; if (busy4  !== 1'b0) begin n_err++; $display("FAIL reset busy4 got %b expected 0", busy4); end
        n_cmp++; if (data4  !== 32'h0) begin n_err++; $display("FAIL reset data4 got %h expected 0", data4); end
        n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL reset valid1 got %b expected 0", valid1); end
        n_cmp++; if (busy1  !== 1'b0) begin n_err++; $display("FAIL reset busy1 got %b expected 0", busy1); end
        n_cmp++; if (data1  !== 32'h0) begin n_err++; $display("FAIL reset data1 got %h expected 0", data1); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_rw();
        do_write(32'h10, 32'hDEADBEEF, WORD);
        read_check(32'h10, WORD, 32'hDEADBEEF, 4, "word_rd_0x10");
    endtask

    task automatic test_byte_half();
        do_write(32'h13, 32'h000000AB, BYTE);
        read_check(32'h12, HALF, 32'h0000ABAD, 4, "half_rd_0x12");
        read_check(32'h13, HALF, 32'h0000ABAD, 4, "half_rd_0x13");
        read_check(32'h10, BYTE, 32'h000000EF, 4, "byte_rd_0x10");
        read_check(32'h11, BYTE, 32'h000000BE, 4, "byte_rd_0x11");
        read_check(32'h10, WORD, 32'hABADBEEF, 4, "word_rd_merged");
        do_write(32'h30, 32'h00000000, WORD);
        do_write(32'h32, 32'h1234CAFE, HALF);
        do_write(32'h31, 32'h5A5A5A77, BYTE);
        read_check(32'h30, WORD, 32'hCAFE7700, 4, "lane_isolation_0x30");
        do_write(32'h10, 32'hDEADBEEF, WORD);
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        @(negedge clk);
        addr = 32'h10; size = WORD; rd_v = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (valid4 === 1'b1) begin
                pulses++;
                n_cmp++;
                if (data4 !== 32'hDEADBEEF) begin
                    n_err++;
                    $display("FAIL busy_ignore data k=%0d got %h expected deadbeef", k, data4);
                end
            end
            rd_v  = (k == 2 || k == 3);
            wr_v  = (k == 1 || k == 3 || k == 4);
            addr  = (k == 2) ? 32'h20 : 32'h10;
            wdata = 32'h0;
            if (k >= 5) begin rd_v = 1'b0; wr_v = 1'b0; end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL busy_ignore pulses got %0d expected 1", pulses);
        end
        read_check(32'h10, WORD, 32'hDEADBEEF, 4, "busy_ignore_mem");
    endtask

    task automatic test_rd_wr_same();
        @(negedge clk);
        addr = 32'h20; wdata = 32'h12345678; size = WORD; rd_v = 1'b1; wr_v = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rd_v = 1'b0; wr_v = 1'b0;
            n_cmp++;
            if (valid4 !== 1'b0 || busy4 !== 1'b0) begin
                n_err++;
                $display("FAIL rd_wr_same k=%0d got valid=%b busy=%b expected 0/0", k, valid4, busy4);
            end
        end
        read_check(32'h20, WORD, 32'h12345678, 4, "rd_wr_same_mem");
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        addr = 32'h10; size = WORD; rd_v = 1'b1;
        @(negedge clk);
        rd_v = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy4 !== 1'b1) begin n_err++; $display("FAIL mid_read busy_before got %b expected 1", busy4); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (valid4 !== 1'b0 || busy4 !== 1'b0 || data4 !== 32'h0) begin
            n_err++;
            $display("FAIL mid_read async_reset got valid=%b busy=%b data=%h expected 0/0/0",
                     valid4, busy4, data4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (valid4 !== 1'b0 || busy4 !== 1'b0) begin
                n_err++;
                $display("FAIL mid_read after_release k=%0d got valid=%b busy=%b expected 0/0",
                         k, valid4, busy4);
            end
        end
        read_check(32'h10, WORD, 32'hDEADBEEF, 4, "mem_kept_over_reset");
    endtask

    task automatic test_wrap();
        read_check(32'h410, WORD, 32'hDEADBEEF, 4, "wrap_rd");
        read_check(32'hFFFF_FC12, HALF, 32'h0000DEAD, 4, "wrap_rd_high_bits");
    endtask

    task automatic test_latency1();
        do_write(32'h40, 32'hCAFEF00D, WORD);
        read_check(32'h40, WORD, 32'hCAFEF00D, 1, "lat1_word");
        read_check(32'h42, BYTE, 32'h000000FE, 1, "lat1_byte");
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_busy_ignore();
        test_rd_wr_same();
        test_reset_mid_read();
        test_wrap();
        test_latency1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
